// File: rtl/event_rr_scheduler_if.sv
// Event-number stream between the round-robin scheduler and the host notification path.
// The master drives data/valid. The slave drives ready.
interface event_rr_scheduler_if #(
    parameter int COUNT_BITS = 4
);
    logic [COUNT_BITS-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/event_rr_scheduler.sv
// Round-robin event scheduler: latches event pulses into pending bits and issues one masked,
// fairly-granted event number at a time, with an optional holdoff gap and sticky overflow flags.
module event_rr_scheduler #(
    parameter int COUNT        = 16,
    parameter int COUNT_BITS   = $clog2(COUNT),
    parameter int HOLDOFF_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_enable,
    input  logic [COUNT-1:0]        cfg_mask,
    input  logic [HOLDOFF_BITS-1:0] cfg_holdoff,
    input  logic [COUNT-1:0]        sn_event_pulse,
    input  logic [COUNT-1:0]        ovf_clear,
    output logic [COUNT-1:0]        stat_pending,
    output logic [COUNT-1:0]        stat_overflow,
    event_rr_scheduler_if.master    m_evno
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OFFER   = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    localparam logic [COUNT-1:0]        ONE_HOT0 = COUNT'(1);
    localparam logic [COUNT_BITS-1:0]   IDX_ONE  = COUNT_BITS'(1);
    localparam logic [COUNT_BITS-1:0]   IDX_LAST = COUNT_BITS'(COUNT - 1);
    localparam logic [HOLDOFF_BITS-1:0] HOLD_ONE = HOLDOFF_BITS'(1);

    logic [1:0]              state_r;
    logic [COUNT_BITS-1:0]   ptr_r;
    logic [COUNT_BITS-1:0]   data_r;
    logic                    valid_r;
    logic [HOLDOFF_BITS-1:0] cnt_r;
    logic [COUNT-1:0]        pending_r;
    logic [COUNT-1:0]        overflow_r;

    logic                    accept_s;
    logic [COUNT-1:0]        accept_vec_s;
    logic [COUNT-1:0]        eligible_s;
    logic [COUNT_BITS-1:0]   grant_s;
    logic [COUNT_BITS-1:0]   ptr_nxt_s;
    logic [COUNT-1:0]        pending_nxt_s;
    logic [COUNT-1:0]        overflow_nxt_s;

    // First set bit of elig, scanning upward from base and wrapping at COUNT-1.
    function automatic logic [COUNT_BITS-1:0] rr_pick(input logic [COUNT-1:0]      elig,
                                                      input logic [COUNT_BITS-1:0] base);
        logic [COUNT_BITS-1:0] pick;
        logic [COUNT-1:0]      sh;
        logic                  found;
        int                    idx;
        pick  = {COUNT_BITS{1'b0}};
        found = 1'b0;
        for (int k = 0; k < COUNT; k++) begin
            idx = int'(base) + k;
            idx = (idx >= COUNT) ? idx - COUNT : idx;
            sh  = elig >> idx;
            if (!found && sh[0]) begin
                pick  = COUNT_BITS'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign accept_s   = valid_r & m_evno.ready;
    assign eligible_s = pending_r & ~cfg_mask;
    assign grant_s    = rr_pick(eligible_s, ptr_r);

    // Next pending/overflow vectors and the pointer value that follows the accepted source.
    always_comb begin
        accept_vec_s   = accept_s ? (ONE_HOT0 << data_r) : {COUNT{1'b0}};
        // A pulse landing on the accept cycle of its own source re-arms pending without loss.
        pending_nxt_s  = (pending_r & ~accept_vec_s) | sn_event_pulse;
        overflow_nxt_s = (overflow_r & ~ovf_clear) | (sn_event_pulse & pending_r & ~accept_vec_s);
        if (data_r == IDX_LAST) begin
            ptr_nxt_s = {COUNT_BITS{1'b0}};
        end else begin
            ptr_nxt_s = data_r + IDX_ONE;
        end
    end

    // Pending and sticky overflow status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r  <= {COUNT{1'b0}};
            overflow_r <= {COUNT{1'b0}};
        end else begin
            pending_r  <= pending_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

    // Offer FSM: IDLE picks a grant, OFFER holds it until accepted, HOLDOFF counts down the gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= {COUNT_BITS{1'b0}};
            data_r  <= {COUNT_BITS{1'b0}};
            valid_r <= 1'b0;
            cnt_r   <= {HOLDOFF_BITS{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cfg_enable && (|eligible_s)) begin
                        data_r  <= grant_s;
                        valid_r <= 1'b1;
                        state_r <= ST_OFFER;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_OFFER: begin
                    // Mask and enable are deliberately ignored here: an offer is never retracted.
                    if (accept_s) begin
                        valid_r <= 1'b0;
                        ptr_r   <= ptr_nxt_s;
                        if (cfg_holdoff == {HOLDOFF_BITS{1'b0}}) begin
                            state_r <= ST_IDLE;
                        end else begin
                            cnt_r   <= cfg_holdoff;
                            state_r <= ST_HOLDOFF;
                        end
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    cnt_r <= cnt_r - HOLD_ONE;
                    if (cnt_r == HOLD_ONE) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLDOFF;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign stat_pending  = pending_r;
    assign stat_overflow = overflow_r;
    assign m_evno.data   = data_r;
    assign m_evno.valid  = valid_r;

endmodule
